comparator_4: RTL and testbench
===============================

# comparator_4

Registered 4-bit magnitude comparator. Each clock it compares unsigned operands A and B and drives three one-hot flags: A less than B, A equal to B, A greater than B. Used as a leaf compare stage wherever a registered, glitch-free relation result is needed one cycle after the operands are sampled.

## Interface
Parameters:
- WIDTH, default 4, operand width in bits. The block must be correct for WIDTH ≥ 1. WIDTH = 4 is the required configuration.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- A  input  WIDTH  operand A, unsigned.
- B  input  WIDTH  operand B, unsigned.
- Y0  output  1  registered flag: A < B.
- Y1  output  1  registered flag: A == B.
- Y2  output  1  registered flag: A > B.

## Operation
- A and B are both unsigned. There is no sign interpretation.
- Comparison logic is a bit-serial cascade from MSB to LSB:
  - Per bit i, eq_i = ~(A[i] ^ B[i]), gt_i = A[i] & ~B[i], lt_i = ~A[i] & B[i].
  - A > B when the highest differing bit has gt_i set, with all higher bits equal.
  - A < B is the same rule with lt_i.
  - A == B is the AND of all eq_i.
- The combinational result must be exactly one-hot: precisely one of lt/eq/gt is 1.
- The result is registered into Y0/Y1/Y2 on every rising clk edge when rst = 0. There is no enable; every cycle samples.
- The output register is the only state. There is no FSM.
- Boundary values must produce correct flags:
  - A = B = 0 gives eq.
  - A = B = 4'hF gives eq.
  - A = 4'hF, B = 0 gives gt.
  - A = 0, B = 4'hF gives lt.
  - Operands that differ only in the LSB are decided by the LSB.

## Timing
- Latency is 1 cycle. Y* at edge n+1 reflect A/B sampled at edge n.
- Reset: when rst = 1 at a rising edge, Y0 = Y1 = Y2 = 0 after that edge. All-zero is the only legal non-one-hot state, and it occurs only during or directly after reset.
- First valid result: the first rising edge with rst = 0 loads the relation of the A/B present at that edge.
- Reset asserted mid-stream: the flags clear on the next edge regardless of operands. The pipeline result in flight is discarded.
- Inputs must meet setup/hold to clk. Outputs come directly from flops and must not glitch between edges.
- Back-to-back operand changes every cycle are supported at full throughput, one result per cycle.

## Test plan
- Reset: hold rst = 1 for 2 cycles with A = 10, B = 9 -> Y0 = Y1 = Y2 = 0. Release rst, and one edge later -> Y2 = 1, Y1 = 0, Y0 = 0.
- Directed sequence, each value held ≥ 2 cycles:
  - A = 10, B = 9 -> Y2 = 1.
  - A = 8, B = 12 -> Y0 = 1.
  - A = 5, B = 5 -> Y1 = 1.
  - A = 12, B = 11 -> Y2 = 1.
  - In every case the other two flags = 0, and each flag updates exactly 1 cycle after the operand change.
- Extremes:
  - A = 0, B = 0 -> Y1.
  - A = 15, B = 15 -> Y1.
  - A = 15, B = 0 -> Y2.
  - A = 0, B = 15 -> Y0.
  - A = 8, B = 7 (MSB decides) -> Y2.
  - A = 6, B = 7 (LSB decides) -> Y0.
- Exhaustive: all 256 A/B pairs, one per cycle -> flags match the reference relation with 1-cycle delay, and exactly one flag is high on every cycle after the first post-reset edge.
- Mid-stream reset: while streaming random operands, assert rst for 1 cycle -> all flags 0 for that cycle. Comparison then resumes correctly on the next edge.

Source files
------------

// File: rtl/comparator_4.sv
// comparator_4: registered unsigned magnitude comparator.
// Y0 = (A < B), Y1 = (A == B), Y2 = (A > B), one cycle after the operands are sampled.
module comparator_4 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Y0,
  output logic             Y1,
  output logic             Y2
);

  localparam int MSB = int'(WIDTH) - 1;

  logic [WIDTH-1:0] eq_bits;
  logic [WIDTH-1:0] gt_bits;
  logic [WIDTH-1:0] lt_bits;

  logic lt_d, eq_d, gt_d;
  logic lt_q, eq_q, gt_q;

  // Per-bit relation terms.
  assign eq_bits = ~(A ^ B);
  assign gt_bits = A & ~B;
  assign lt_bits = ~A & B;

  // MSB-to-LSB cascade: the highest differing bit decides gt/lt; eq only when no bit differs.
  always_comb begin
    logic decided;
    decided = 1'b0;
    gt_d    = 1'b0;
    lt_d    = 1'b0;
    for (int i = MSB; i >= 0; i--) begin
      if (!decided && !eq_bits[i]) begin
        decided = 1'b1;
        gt_d    = gt_bits[i];
        lt_d    = lt_bits[i];
      end
    end
    eq_d = &eq_bits;
  end

  // Output register: cleared by synchronous reset, otherwise samples every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      lt_q <= 1'b0;
      eq_q <= 1'b0;
      gt_q <= 1'b0;
    end else begin
      lt_q <= lt_d;
      eq_q <= eq_d;
      gt_q <= gt_d;
    end
  end

  assign Y0 = lt_q;
  assign Y1 = eq_q;
  assign Y2 = gt_q;

endmodule

// File: tb/tb_comparator_4.sv
// Directed and exhaustive bench for comparator_4; flags compared as {Y2,Y1,Y0}.
module tb_comparator_4;

  localparam int unsigned WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             y0, y1, y2;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  comparator_4 #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .A  (a),
    .B  (b),
    .Y0 (y0),
    .Y1 (y1),
    .Y2 (y2)
  );

  // Reference relation as {gt, eq, lt}.
  function automatic logic [2:0] ref_rel(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    if (x > y)       return 3'b100;
    else if (x == y) return 3'b010;
    else             return 3'b001;
  endfunction

  // Apply inputs away from the active edge.
  task automatic drive(input logic r, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    @(negedge clk);
    rst = r;
    a   = x;
    b   = y;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a   = 4'd10;
    b   = 4'd9;
    for (int c = 0; c < 2; c++) begin
      tick();
      vectors++;
      if ({y2, y1, y0} !== 3'b000) begin
        miscompares++;
        $display("FAIL reset_hold cycle %0d: got %b expected 000", c, {y2, y1, y0});
      end
    end
    drive(1'b0, 4'd10, 4'd9);
    tick();
    vectors++;
    if ({y2, y1, y0} !== 3'b100) begin
      miscompares++;
      $display("FAIL reset_release: got %b expected 100", {y2, y1, y0});
    end
  endtask

  task automatic test_directed();
    logic [WIDTH-1:0] da [4];
    logic [WIDTH-1:0] db [4];
    logic [2:0]       de [4];
    logic [2:0]       prev;
    da = '{4'd10, 4'd8,  4'd5, 4'd12};
    db = '{4'd9,  4'd12, 4'd5, 4'd11};
    de = '{3'b100, 3'b001, 3'b010, 3'b100};
    prev = 3'b100;
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, da[k], db[k]);
      #1;
      vectors++;
      if ({y2, y1, y0} !== prev) begin
        miscompares++;
        $display("FAIL directed_early %0d: got %b expected %b", k, {y2, y1, y0}, prev);
      end
      for (int c = 0; c < 2; c++) begin
        tick();
        vectors++;
        if ({y2, y1, y0} !== de[k]) begin
          miscompares++;
          $display("FAIL directed %0d A=%0d B=%0d cycle %0d: got %b expected %b",
                   k, da[k], db[k], c, {y2, y1, y0}, de[k]);
        end
      end
      prev = de[k];
    end
  endtask

  task automatic test_extremes();
    logic [WIDTH-1:0] ea [6];
    logic [WIDTH-1:0] eb [6];
    logic [2:0]       ee [6];
    ea = '{4'd0, 4'd15, 4'd15, 4'd0,  4'd8, 4'd6};
    eb = '{4'd0, 4'd15, 4'd0,  4'd15, 4'd7, 4'd7};
    ee = '{3'b010, 3'b010, 3'b100, 3'b001, 3'b100, 3'b001};
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, ea[k], eb[k]);
      tick();
      vectors++;
      if ({y2, y1, y0} !== ee[k]) begin
        miscompares++;
        $display("FAIL extreme A=%0d B=%0d: got %b expected %b", ea[k], eb[k], {y2, y1, y0}, ee[k]);
      end
    end
  endtask

  task automatic test_exhaustive();
    logic [WIDTH-1:0] x, y;
    for (int i = 0; i < 256; i++) begin
      x = 4'(i >> 4);
      y = 4'(i);
      drive(1'b0, x, y);
      tick();
      vectors++;
      if ({y2, y1, y0} !== ref_rel(x, y)) begin
        miscompares++;
        $display("FAIL exhaustive A=%0d B=%0d: got %b expected %b", x, y, {y2, y1, y0}, ref_rel(x, y));
      end
      vectors++;
      if ($countones({y2, y1, y0}) != 1) begin
        miscompares++;
        $display("FAIL onehot A=%0d B=%0d: got %b expected exactly one bit set", x, y, {y2, y1, y0});
      end
    end
  endtask

  task automatic test_midstream_reset();
    logic [WIDTH-1:0] x, y;
    for (int c = 0; c < 20; c++) begin
      x = 4'($urandom_range(0, 15));
      y = 4'($urandom_range(0, 15));
      drive((c == 10) ? 1'b1 : 1'b0, x, y);
      tick();
      vectors++;
      if (c == 10) begin
        if ({y2, y1, y0} !== 3'b000) begin
          miscompares++;
          $display("FAIL midreset A=%0d B=%0d: got %b expected 000", x, y, {y2, y1, y0});
        end
      end else if ({y2, y1, y0} !== ref_rel(x, y)) begin
        miscompares++;
        $display("FAIL midstream %0d A=%0d B=%0d: got %b expected %b", c, x, y, {y2, y1, y0}, ref_rel(x, y));
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_extremes();
    test_exhaustive();
    test_midstream_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
